// File: rtl/mpc_ddr_rx_align_pkg.sv
// Shared FSM state type, training defaults and idle-bus constant for the MPC DDR receive path.
// Latency: none, declarations only.
// Backpressure: not applicable.
package mpc_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HUNT,
        ST_CHECK,
        ST_LOCKED
    } rx_state_t;

    localparam logic [7:0] TRAIN_1ST_DEF = 8'hAA;
    localparam logic [7:0] TRAIN_2ND_DEF = 8'h55;

    localparam int IDLE_MAXW = 64;

    // Idle MPC bus level is all-ones; callers truncate to their own width.
    function automatic logic [IDLE_MAXW-1:0] idle_ones();
        return {IDLE_MAXW{1'b1}};
    endfunction

endpackage

// File: rtl/mpc_ddr_rx_align_capture.sv
// Both-edge capture of the 80 MHz MPC bus and 1st/2nd pairing with optional phase swap.
// Latency: pair is combinational from the capture flops, valid before the next posedge.
// Backpressure: none; a new pair every clock cycle.
module mpc_ddr_capture
    import mpc_rx_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [WIDTH-1:0]   din,
    input  logic               swap,
    output logic [2*WIDTH-1:0] pair
);
    localparam logic [WIDTH-1:0] IDLE_W = WIDTH'(idle_ones());

    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] fall_q_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rise_q   <= IDLE_W;
            fall_q_d <= IDLE_W;
        end else begin
            rise_q   <= din;
            fall_q_d <= fall_q;
        end
    end

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fall_q <= IDLE_W;
        end else begin
            fall_q <= din;
        end
    end

    // swap=1 pairs the negedge sample preceding rise_q, held in fall_q_d.
    assign pair = swap ? {fall_q_d, rise_q} : {rise_q, fall_q};

endmodule

// File: rtl/mpc_ddr_rx_align.sv
// MPC DDR receiver: pairs both-edge samples, delays them by dly cycles, trains lock on a fixed pattern.
// Latency: 1 + dly cycles from the posedge capturing the 1st word (swap=0).
// Backpressure: none; output words update every clock cycle.
module mpc_ddr_rx_align
    import mpc_rx_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               MAXDLY    = 7,
    parameter logic [WIDTH-1:0] TRAIN_1ST = WIDTH'(TRAIN_1ST_DEF),
    parameter logic [WIDTH-1:0] TRAIN_2ND = WIDTH'(TRAIN_2ND_DEF),
    parameter int               LOCK_CNT  = 16,
    parameter int               ERRW      = 12,
    localparam int              DW        = $clog2(MAXDLY + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    input  logic             swap,
    input  logic [DW-1:0]    dly,
    input  logic             train_en,
    input  logic             err_cnt_clr,
    output logic [WIDTH-1:0] dout1st,
    output logic [WIDTH-1:0] dout2nd,
    output logic             locked,
    output logic             phase_err,
    output logic [ERRW-1:0]  err_cnt
);
    localparam int            PW        = 2 * WIDTH;
    localparam int            CW        = $clog2(LOCK_CNT + 1);
    localparam logic [PW-1:0] IDLE_PAIR = PW'(idle_ones());
    localparam logic [PW-1:0] GOOD_PAIR = {TRAIN_1ST, TRAIN_2ND};
    localparam logic [PW-1:0] SWAP_PAIR = {TRAIN_2ND, TRAIN_1ST};
    localparam logic [CW-1:0] LAST_CNT  = CW'(LOCK_CNT - 1);

    logic [PW-1:0] pair;
    logic [PW-1:0] dline   [1:MAXDLY];
    logic [PW-1:0] tap_sel [0:(1<<DW)-1];
    logic [PW-1:0] dout_q;
    rx_state_t     state;
    logic [CW-1:0] match_cnt;
    logic          train_en_q;

    mpc_ddr_capture #(.WIDTH(WIDTH)) u_capture (
        .clock   (clock),
        .reset_n (reset_n),
        .din     (din),
        .swap    (swap),
        .pair    (pair)
    );

    // Select encodings above MAXDLY alias onto the deepest tap.
    for (genvar i = 0; i < (1 << DW); i++) begin : g_tap
        localparam int J = (i > MAXDLY) ? MAXDLY : i;
        if (J == 0) begin : g_direct
            assign tap_sel[i] = pair;
        end else begin : g_line
            assign tap_sel[i] = dline[J];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 1; i <= MAXDLY; i++) dline[i] <= IDLE_PAIR;
            dout_q <= IDLE_PAIR;
        end else begin
            dline[1] <= pair;
            for (int i = 2; i <= MAXDLY; i++) dline[i] <= dline[i-1];
            dout_q <= tap_sel[dly];
        end
    end

    assign dout1st = dout_q[PW-1:WIDTH];
    assign dout2nd = dout_q[WIDTH-1:0];

    // Training looks at the undelayed pair so dly never disturbs lock.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            match_cnt  <= '0;
            locked     <= 1'b0;
            phase_err  <= 1'b0;
            train_en_q <= 1'b0;
        end else begin
            train_en_q <= train_en;
            phase_err  <= 1'b0;
            if (!train_en) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (!train_en_q) begin
                            state     <= ST_HUNT;
                            locked    <= 1'b0;
                            match_cnt <= '0;
                        end
                    end
                    ST_HUNT: begin
                        if (pair == GOOD_PAIR) begin
                            state     <= ST_CHECK;
                            match_cnt <= CW'(1);
                        end else if (pair == SWAP_PAIR) begin
                            phase_err <= 1'b1;
                        end
                    end
                    ST_CHECK: begin
                        if (pair != GOOD_PAIR) begin
                            state     <= ST_HUNT;
                            match_cnt <= '0;
                        end else begin
                            match_cnt <= match_cnt + CW'(1);
                            if (match_cnt == LAST_CNT) begin
                                state  <= ST_LOCKED;
                                locked <= 1'b1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt <= '0;
        end else if (err_cnt_clr) begin
            err_cnt <= '0;
        end else if (train_en && state == ST_LOCKED && pair != GOOD_PAIR && err_cnt != '1) begin
            err_cnt <= err_cnt + ERRW'(1);
        end
    end

endmodule

// File: tb/tb_mpc_ddr_rx_align.sv
// Bench for mpc_ddr_rx_align: directed stimulus queues timed expectations, a negedge monitor checks them.
module tb_mpc_ddr_rx_align;

    logic        clock;
    logic        reset_n;
    logic [7:0]  din;
    logic        swap;
    logic [2:0]  dly;
    logic        train_en;
    logic        err_cnt_clr;
    logic [7:0]  dout1st;
    logic [7:0]  dout2nd;
    logic        locked;
    logic        phase_err;
    logic [11:0] err_cnt;

    mpc_ddr_rx_align dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .din         (din),
        .swap        (swap),
        .dly         (dly),
        .train_en    (train_en),
        .err_cnt_clr (err_cnt_clr),
        .dout1st     (dout1st),
        .dout2nd     (dout2nd),
        .locked      (locked),
        .phase_err   (phase_err),
        .err_cnt     (err_cnt)
    );

    localparam logic [1:0] K_DOUT = 2'd0;
    localparam logic [1:0] K_LOCK = 2'd1;
    localparam logic [1:0] K_PE   = 2'd2;
    localparam logic [1:0] K_ERR  = 2'd3;

    typedef struct packed {
        int          at;
        int          tag;
        logic [1:0]  kind;
        logic [15:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    initial clock = 1'b0;
    always #10 clock = ~clock;
    always @(posedge clock) cyc++;

    function automatic string kind_name(input logic [1:0] kind);
        case (kind)
            K_DOUT:  return "dout";
            K_LOCK:  return "locked";
            K_PE:    return "phase_err";
            default: return "err_cnt";
        endcase
    endfunction

    function automatic logic [15:0] actual(input logic [1:0] kind);
        case (kind)
            K_DOUT:  return {dout1st, dout2nd};
            K_LOCK:  return {15'd0, locked};
            K_PE:    return {15'd0, phase_err};
            default: return {4'd0, err_cnt};
        endcase
    endfunction

    // Monitor: every expectation due at or before this cycle is popped and compared.
    always @(negedge clock) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].at <= cyc) begin
                checks++;
                if (exp_q[i].at != cyc || actual(exp_q[i].kind) != exp_q[i].val) begin
                    failures++;
                    $display("FAIL %s[step %0d] cyc=%0d due=%0d got=%h expected=%h",
                             kind_name(exp_q[i].kind), exp_q[i].tag, cyc, exp_q[i].at,
                             actual(exp_q[i].kind), exp_q[i].val);
                end
                exp_q.delete(i);
            end
        end
    end

    task automatic expect_at(input int at, input int tag, input logic [1:0] kind, input logic [15:0] val);
        exp_t e;
        e.at   = at;
        e.tag  = tag;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    // a is sampled on posedge k (returned), b on the following negedge.
    task automatic drive(input logic [7:0] a, input logic [7:0] b, output int k);
        @(negedge clock);
        #2 din = a;
        @(posedge clock);
        #2 din = b;
        k = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not reach its summary, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int t;
        int n;
        reset_n     = 1'b0;
        din         = 8'h00;
        swap        = 1'b0;
        dly         = 3'd0;
        train_en    = 1'b0;
        err_cnt_clr = 1'b0;

        // Step 0: outputs hold idle values under reset while din toggles.
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            #2 din = 8'($urandom);
            @(posedge clock);
            #2 din = 8'($urandom);
            expect_at(cyc, 0, K_DOUT, 16'hFFFF);
            expect_at(cyc, 0, K_LOCK, 16'd0);
            expect_at(cyc, 0, K_PE,   16'd0);
            expect_at(cyc, 0, K_ERR,  16'd0);
        end
        reset_n = 1'b1;

        // Step 1/2: plain pairing, then swapped pairing.
        drive(8'h12, 8'h34, k); expect_at(k + 1, 1, K_DOUT, 16'h1234);
        drive(8'h9A, 8'hBC, k); expect_at(k + 1, 1, K_DOUT, 16'h9ABC);
        idle(1);
        swap = 1'b1;
        drive(8'h12, 8'h34, k); expect_at(k + 1, 2, K_DOUT, 16'hBC12);
        drive(8'hAB, 8'hCD, k); expect_at(k + 1, 2, K_DOUT, 16'h34AB);
        idle(1);
        swap = 1'b0;

        // Step 3: delay sweep with a counting pattern.
        n = 0;
        for (int d = 0; d <= 7; d++) begin
            dly = 3'(d);
            for (int j = 0; j < 3; j++) begin
                drive(8'(2 * n), 8'(2 * n + 1), k);
                expect_at(k + 1 + d, 3, K_DOUT, {8'(2 * n), 8'(2 * n + 1)});
                n++;
            end
            idle(d + 1);
        end
        dly = 3'd0;

        // Step 4: swapped training stream flags phase_err, then swap=1 locks.
        train_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(8'h55, 8'hAA, k);
            expect_at(k + 1, 4, K_PE,   16'd1);
            expect_at(k + 1, 4, K_LOCK, 16'd0);
        end
        expect_at(k + 2, 4, K_PE, 16'd0);
        idle(2);
        swap = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(8'h55, 8'hAA, k);
            if (i == 14) expect_at(k + 1, 4, K_LOCK, 16'd0);
            if (i == 15) expect_at(k + 1, 4, K_LOCK, 16'd1);
        end
        expect_at(k + 2, 4, K_ERR, 16'd1);
        idle(2);
        train_en = 1'b0;
        expect_at(k + 3, 4, K_LOCK, 16'd1);
        expect_at(k + 4, 4, K_ERR,  16'd1);
        idle(3);
        swap = 1'b0;

        // Step 5: retrain; a bad pair at position 10 restarts the 16-pair count.
        train_en    = 1'b1;
        err_cnt_clr = 1'b1;
        t = cyc;
        expect_at(t + 1, 5, K_LOCK, 16'd0);
        expect_at(t + 1, 5, K_ERR,  16'd0);
        idle(1);
        err_cnt_clr = 1'b0;
        for (int i = 0; i < 9; i++) drive(8'hAA, 8'h55, k);
        drive(8'hAA, 8'h00, k);
        expect_at(k + 1, 5, K_LOCK, 16'd0);
        for (int i = 0; i < 16; i++) begin
            drive(8'hAA, 8'h55, k);
            if (i == 14) expect_at(k + 1, 5, K_LOCK, 16'd0);
            if (i == 15) expect_at(k + 1, 5, K_LOCK, 16'd1);
        end

        // Step 6: error counting, clear priority, saturation, sticky lock.
        for (int i = 0; i < 3; i++) begin
            drive(8'hAA, 8'h00, k);
            expect_at(k + 1, 6, K_ERR, 16'(i + 1));
        end
        drive(8'hAA, 8'h00, k);
        err_cnt_clr = 1'b1;
        expect_at(k + 1, 6, K_ERR, 16'd0);
        t = k;
        idle(1);
        err_cnt_clr = 1'b0;
        expect_at(t + 1 + 4094, 6, K_ERR,  16'h0FFE);
        expect_at(t + 1 + 4095, 6, K_ERR,  16'h0FFF);
        expect_at(t + 1 + 4100, 6, K_ERR,  16'h0FFF);
        expect_at(t + 1 + 4100, 6, K_LOCK, 16'd1);
        idle(4102);
        train_en = 1'b0;
        expect_at(cyc + 2, 7, K_LOCK, 16'd1);
        expect_at(cyc + 2, 7, K_ERR,  16'h0FFF);
        idle(4);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending: %0d expectations never reached, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
